rs_syndrome_calc: RTL

- First stage of the RS(31,31-2T) decoder over GF(2^5), primitive polynomial x^5+x^2+1, alpha = 5'b00010.
- Consumes the received codeword serially, one 5-bit symbol per accepted cycle, highest-degree symbol first.
- Produces the 2T syndromes S_j = r(alpha^j), j=1..2T, for the downstream key-equation solver.
- Computes each syndrome by Horner recursion with one constant GF multiplier and one gfadder per syndrome lane.

---
 rtl/rs_syndrome_calc.sv | 108 ++++++++++
 1 files changed

// File: rtl/rs_syndrome_calc.sv
// RS(31,31-2T) syndrome calculator over GF(2^5) (x^5+x^2+1): 2T Horner lanes fed one symbol per accept.
// Optional SYND_OVERFLOW_DET_EN builds the sticky overflow detector for unacknowledged completions.

module rs_syndrome_lane #(
    parameter int J = 1
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [4:0] sym_in,
    input  logic       load,
    input  logic       step,
    output logic [4:0] horner
);
    logic [4:0] acc;

    // Multiply by the fixed constant alpha^n: n repeated multiply-by-x steps, which collapses to an XOR network.
    function automatic logic [4:0] mul_alpha_pow(input logic [4:0] a, input int n);
        logic [4:0] r;
        r = a;
        for (int i = 0; i < n; i++)
            r = {r[3:0], 1'b0} ^ (r[4] ? 5'b00101 : 5'b00000);
        return r;
    endfunction

    assign horner = mul_alpha_pow(acc, J) ^ sym_in;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)  acc <= '0;
        else if (load) acc <= sym_in;
        else if (step) acc <= horner;
    end
endmodule

module rs_syndrome_calc #(
    parameter int T    = 2,
    parameter int NSYM = 31
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic [4:0]      sym_in,
    input  logic            sym_valid,
    input  logic            sym_sop,
    output logic [10*T-1:0] synd_out,
    output logic            synd_valid,
    input  logic            synd_ack,
    output logic            error_flag,
    output logic            overflow
);
    localparam int NUM_LANES = 2 * T;
    localparam int CW        = $clog2(NSYM);

    logic [CW-1:0]                sym_cnt;
    logic [NUM_LANES-1:0][4:0]    horner;
    logic [NUM_LANES-1:0][4:0]    synd_q;
    logic                         load_first, last, step;

    // sym_sop restarts a block at any count, discarding whatever was in flight.
    assign load_first = sym_valid && ((sym_cnt == '0) || sym_sop);
    assign last       = sym_valid && !load_first && (sym_cnt == CW'(NSYM - 1));
    assign step       = sym_valid && !load_first && !last;

    genvar g;
    generate
        for (g = 0; g < NUM_LANES; g++) begin : g_lane
            rs_syndrome_lane #(.J(g + 1)) u_lane (
                .clock   (clock),
                .reset_n (reset_n),
                .sym_in  (sym_in),
                .load    (load_first),
                .step    (step),
                .horner  (horner[g])
            );
        end
    endgenerate

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)        sym_cnt <= '0;
        else if (load_first) sym_cnt <= CW'(1);
        else if (last)       sym_cnt <= '0;
        else if (step)       sym_cnt <= sym_cnt + CW'(1);
    end

    // A completing block wins over a simultaneous ack, so valid stays high.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            synd_q     <= '0;
            synd_valid <= 1'b0;
            error_flag <= 1'b0;
        end else if (last) begin
            synd_q     <= horner;
            synd_valid <= 1'b1;
            error_flag <= |horner;
        end else if (synd_ack) begin
            synd_valid <= 1'b0;
        end
    end

    assign synd_out = synd_q;

`ifdef SYND_OVERFLOW_DET_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                             overflow <= 1'b0;
        else if (last && synd_valid && !synd_ack) overflow <= 1'b1;
    end
`else
    assign overflow = 1'b0;
`endif
endmodule
